mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage ARMLEG pipeline, directly downstream of the EX/MEM register and feeding WB.
- Resolves CBZ-style branches from EX/MEM flags.
- Performs loads and stores over a req/ack data-memory handshake, stalling the front of the pipeline until memory acknowledges.
- Registers the MEM/WB pipeline values, inserting bubbles while stalled.

Parameters:
DATA_W, 64, datapath/address width
TIMEOUT, 16, max cycles waiting for dmemAck before abort (>=2)

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  reset; synchronous, active-high
isBranch_in  in  1  EX/MEM branch flag
memRead_in  in  1  EX/MEM load flag
memWrite_in  in  1  EX/MEM store flag
regWrite_in  in  1  EX/MEM WB-enable
memToReg_in  in  1  EX/MEM WB-select
shiftedProgramCounter_in  in  DATA_W  branch target
ALUzero_in  in  1  ALU zero flag
ALUresult_in  in  DATA_W  address / ALU result
writeDataMem_in  in  DATA_W  store data
writeReg_in  in  5  destination register
dmemReq_out  out  1  memory request valid
dmemWe_out  out  1  1 = store
dmemAddr_out  out  DATA_W  memory address
dmemWdata_out  out  DATA_W  store data
dmemAck_in  in  1  memory completion (one-cycle pulse)
dmemRdata_in  in  DATA_W  load data, valid with ack
stall_out  out  1  hold PC, IF/ID, ID/EX, EX/MEM
pcSrc_out  out  1  take branch
branchTarget_out  out  DATA_W  = shiftedProgramCounter_in
dmemErr_out  out  1  sticky timeout / illegal-op flag
regWrite_out  out  1  MEM/WB WB-enable
memToReg_out  out  1  MEM/WB WB-select
readData_out  out  DATA_W  MEM/WB load data
ALUresult_out  out  DATA_W  MEM/WB ALU result
writeReg_out  out  5  MEM/WB destination

Behaviour:
- FSM states: IDLE, WAIT.
- memOp = memRead_in | memWrite_in.
- Illegal op: memRead_in & memWrite_in. Treated as a read (dmemWe_out=0) and sets dmemErr_out.
- IDLE, memOp=0:
  - No request issued; stall_out=0.
  - Next edge: MEM/WB registers load the *_in values; readData_out <= 0.
- IDLE, memOp=1:
  - dmemReq_out=1 combinationally; dmemAddr_out=ALUresult_in; dmemWdata_out=writeDataMem_in; dmemWe_out=memWrite_in & ~memRead_in.
  - If dmemAck_in is high the same cycle: retire. stall_out=0; MEM/WB loads; readData_out <= dmemRdata_in on a read, else 0.
  - Otherwise: stall_out=1; go to WAIT; clear the wait counter; MEM/WB loads a bubble (regWrite_out <= 0, other fields hold).
- WAIT:
  - dmemReq_out=1 and all dmem* outputs held from the *_in ports (EX/MEM is frozen by stall_out).
  - stall_out = ~dmemAck_in.
  - On ack: retire as above; go to IDLE.
  - Without ack: counter increments and a bubble is written.
- Timeout: counter reaching TIMEOUT-1 with no ack in WAIT:
  - Abort the access: set dmemErr_out; stall_out=0 in that cycle.
  - Write a bubble (instruction discarded; regWrite_out <= 0); go to IDLE.
- Late ack: an ack arriving in IDLE while memOp=0 is ignored.
- Branch:
  - pcSrc_out = isBranch_in & ALUzero_in & ~stall_out (combinational).
  - branchTarget_out = shiftedProgramCounter_in.
  - A branch carrying memOp is illegal: memory takes precedence and pcSrc_out waits until retire.
- dmemErr_out: sticky until RESET.
- RESET:
  - At the next edge the FSM goes to IDLE, the counter clears, and all registered outputs become 0.
  - dmemReq_out, stall_out and pcSrc_out are forced to 0 while RESET=1, including mid-WAIT. The outstanding access is abandoned, and an ack arriving after reset is ignored.
- Latency:
  - Non-memory op: 1 cycle to MEM/WB.
  - Memory op: 1 + (cycles until ack).
  - Stall cycles: ack delay in cycles, bounded by TIMEOUT-1.

Decomposition:
- Package arm_pipe_pkg: mem_state_t enum {IDLE, WAIT}, DATA_W default, REG_ADDR_W=5.
- Sub-module memwb_reg: the MEM/WB register with a bubble input that forces regWrite=0. Also reusable for a future flush.

Test Plan:
- ALU op (regWrite=1, writeReg=5, ALUresult=0x2A, no memOp) -> next edge regWrite_out=1, ALUresult_out=0x2A, writeReg_out=5; stall_out never 1.
- Load at 0x100, ack on 3rd cycle with rdata 0xDEAD -> dmemReq high 3 cycles at addr 0x100; stall_out=1 for 2 cycles; then readData_out=0xDEAD, regWrite_out=1; bubbles in between.
- Store 0xBEEF to 0x40, same-cycle ack -> dmemWe_out=1, dmemWdata_out=0xBEEF, no stall, regWrite_out=0 (as supplied).
- Load with no ack, TIMEOUT=16 -> stall_out high for 15 cycles, then dmemErr_out=1, bubble, FSM IDLE; next ALU op proceeds normally.
- Branch isBranch=1, ALUzero=1, target 0x80 -> pcSrc_out=1, branchTarget_out=0x80 same cycle; with ALUzero=0 -> pcSrc_out=0.
- RESET asserted in WAIT, then ack one cycle after reset release -> all outputs 0, dmemReq_out=0, ack ignored, dmemErr_out=0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARMLEG pipeline stages.
package arm_pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Read and write together has no defined meaning; the stage treats it as a read and flags it.
    function automatic logic is_illegal_op(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register; a bubble clears the write-back enable and holds the other fields.
import arm_pipe_pkg::*;

module memwb_reg #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bubble_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [REG_W-1:0]  write_reg_i,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [REG_W-1:0]  write_reg_o
);

    logic              reg_write_q,  reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0] read_data_q,  read_data_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [REG_W-1:0]  write_reg_q,  write_reg_d;

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        if (bubble_i) begin
            reg_write_d = 1'b0;
        end else begin
            reg_write_d  = reg_write_i;
            mem_to_reg_d = mem_to_reg_i;
            read_data_d  = read_data_i;
            alu_result_d = alu_result_i;
            write_reg_d  = write_reg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign reg_write_o  = reg_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_stage.sv
// ARMLEG memory stage: branch resolution, req/ack data-memory access with timeout, MEM/WB register.
//   state | meaning
//   IDLE  | no access outstanding; a memory op issues its request here
//   WAIT  | request outstanding, upstream frozen until ack or timeout
import arm_pipe_pkg::*;

module mem_stage #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  isBranch_in,
    input  logic                  memRead_in,
    input  logic                  memWrite_in,
    input  logic                  regWrite_in,
    input  logic                  memToReg_in,
    input  logic [DATA_W-1:0]     shiftedProgramCounter_in,
    input  logic                  ALUzero_in,
    input  logic [DATA_W-1:0]     ALUresult_in,
    input  logic [DATA_W-1:0]     writeDataMem_in,
    input  logic [REG_ADDR_W-1:0] writeReg_in,
    output logic                  dmemReq_out,
    output logic                  dmemWe_out,
    output logic [DATA_W-1:0]     dmemAddr_out,
    output logic [DATA_W-1:0]     dmemWdata_out,
    input  logic                  dmemAck_in,
    input  logic [DATA_W-1:0]     dmemRdata_in,
    output logic                  stall_out,
    output logic                  pcSrc_out,
    output logic [DATA_W-1:0]     branchTarget_out,
    output logic                  dmemErr_out,
    output logic                  regWrite_out,
    output logic                  memToReg_out,
    output logic [DATA_W-1:0]     readData_out,
    output logic [DATA_W-1:0]     ALUresult_out,
    output logic [REG_ADDR_W-1:0] writeReg_out
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The IDLE issue cycle already stalls once, so WAIT aborts one count early to cap stalls at TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic              mem_op;
    logic              illegal;
    logic              mem_req;
    logic              timeout;
    logic              retire;
    logic              stall_raw;
    logic              bubble;
    logic [DATA_W-1:0] rdata_sel;

    assign mem_op  = memRead_in | memWrite_in;
    assign illegal = is_illegal_op(memRead_in, memWrite_in);

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (mem_op && !dmemAck_in) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        end else begin
            if (dmemAck_in || timeout) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if ((mem_req && illegal) || timeout) begin
            err_d = 1'b1;
        end
    end

    // Output decode
    always_comb begin
        mem_req   = (state_q == WAIT) || mem_op;
        timeout   = (state_q == WAIT) && !dmemAck_in && (cnt_q == CNT_LAST);
        retire    = mem_req && dmemAck_in;
        stall_raw = mem_req && !dmemAck_in && !timeout;
        bubble    = mem_req && !dmemAck_in;
        rdata_sel = (retire && memRead_in) ? dmemRdata_in : '0;
    end

    assign dmemReq_out      = mem_req & ~RESET;
    assign dmemWe_out       = dmemReq_out & memWrite_in & ~memRead_in;
    assign dmemAddr_out     = ALUresult_in;
    assign dmemWdata_out    = writeDataMem_in;
    assign stall_out        = stall_raw & ~RESET;
    assign pcSrc_out        = isBranch_in & ALUzero_in & ~stall_out & ~RESET;
    assign branchTarget_out = shiftedProgramCounter_in;
    assign dmemErr_out      = err_q;

    memwb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_ADDR_W)
    ) u_memwb (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .bubble_i     (bubble),
        .reg_write_i  (regWrite_in),
        .mem_to_reg_i (memToReg_in),
        .read_data_i  (rdata_sel),
        .alu_result_i (ALUresult_in),
        .write_reg_i  (writeReg_in),
        .reg_write_o  (regWrite_out),
        .mem_to_reg_o (memToReg_out),
        .read_data_o  (readData_out),
        .alu_result_o (ALUresult_out),
        .write_reg_o  (writeReg_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plan cases then random instructions against a transaction-level model.
module tb_mem_stage;

    localparam int DW      = 64;
    localparam int TIMEOUT = 16;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          isBranch_in = 0, memRead_in = 0, memWrite_in = 0;
    logic          regWrite_in = 0, memToReg_in = 0, ALUzero_in = 0;
    logic [DW-1:0] shiftedProgramCounter_in = '0, ALUresult_in = '0, writeDataMem_in = '0;
    logic [4:0]    writeReg_in = '0;
    logic          dmemAck_in = 0;
    logic [DW-1:0] dmemRdata_in = '0;
    logic          dmemReq_out, dmemWe_out, stall_out, pcSrc_out, dmemErr_out;
    logic [DW-1:0] dmemAddr_out, dmemWdata_out, branchTarget_out;
    logic          regWrite_out, memToReg_out;
    logic [DW-1:0] readData_out, ALUresult_out;
    logic [4:0]    writeReg_out;

    always #5 CLOCK = ~CLOCK;

    mem_stage #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .isBranch_in(isBranch_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .regWrite_in(regWrite_in), .memToReg_in(memToReg_in),
        .shiftedProgramCounter_in(shiftedProgramCounter_in), .ALUzero_in(ALUzero_in),
        .ALUresult_in(ALUresult_in), .writeDataMem_in(writeDataMem_in), .writeReg_in(writeReg_in),
        .dmemReq_out(dmemReq_out), .dmemWe_out(dmemWe_out), .dmemAddr_out(dmemAddr_out),
        .dmemWdata_out(dmemWdata_out), .dmemAck_in(dmemAck_in), .dmemRdata_in(dmemRdata_in),
        .stall_out(stall_out), .pcSrc_out(pcSrc_out), .branchTarget_out(branchTarget_out),
        .dmemErr_out(dmemErr_out), .regWrite_out(regWrite_out), .memToReg_out(memToReg_out),
        .readData_out(readData_out), .ALUresult_out(ALUresult_out), .writeReg_out(writeReg_out)
    );

    typedef struct {
        logic          isb, rd, wr, rw, m2r, az, stray_ack;
        logic [DW-1:0] tgt, alu, wd, rdata;
        logic [4:0]    wreg;
        int            ack_at;   // cycle of ack (1 = same cycle); outside 1..TIMEOUT means never
    } instr_t;

    int n_chk = 0;
    int n_fail = 0;

    // Expected MEM/WB contents and error flag
    logic          exp_rw, exp_m2r, exp_err;
    logic [DW-1:0] exp_rdata, exp_alu;
    logic [4:0]    exp_wreg;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        isBranch_in = 0; memRead_in = 0; memWrite_in = 0; regWrite_in = 0; memToReg_in = 0;
        ALUzero_in = 0; shiftedProgramCounter_in = '0; ALUresult_in = '0; writeDataMem_in = '0;
        writeReg_in = '0; dmemAck_in = 0; dmemRdata_in = '0;
    endtask

    task automatic check_memwb(input string pfx);
        chk({pfx, "_regWrite"}, {63'd0, regWrite_out}, {63'd0, exp_rw});
        chk({pfx, "_memToReg"}, {63'd0, memToReg_out}, {63'd0, exp_m2r});
        chk({pfx, "_readData"}, readData_out, exp_rdata);
        chk({pfx, "_ALUresult"}, ALUresult_out, exp_alu);
        chk({pfx, "_writeReg"}, {59'd0, writeReg_out}, {59'd0, exp_wreg});
        chk({pfx, "_err"}, {63'd0, dmemErr_out}, {63'd0, exp_err});
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_req", {63'd0, dmemReq_out}, 64'd0);
        chk("rst_stall", {63'd0, stall_out}, 64'd0);
        RESET = 1'b0;
        exp_rw = 0; exp_m2r = 0; exp_rdata = '0; exp_alu = '0; exp_wreg = '0; exp_err = 0;
        check_memwb("rst");
    endtask

    // Caller is positioned just after a rising edge; returns just after the retiring edge.
    task automatic run_instr(input instr_t in);
        logic mem_op, to, exp_stall;
        int   len;
        mem_op = in.rd | in.wr;
        to     = mem_op && !(in.ack_at >= 1 && in.ack_at <= TIMEOUT);
        len    = !mem_op ? 1 : (to ? TIMEOUT : in.ack_at);
        isBranch_in = in.isb; memRead_in = in.rd; memWrite_in = in.wr; regWrite_in = in.rw;
        memToReg_in = in.m2r; ALUzero_in = in.az; shiftedProgramCounter_in = in.tgt;
        ALUresult_in = in.alu; writeDataMem_in = in.wd; writeReg_in = in.wreg;
        for (int c = 1; c <= len; c++) begin
            dmemAck_in   = mem_op ? (c == in.ack_at) : in.stray_ack;
            dmemRdata_in = (mem_op && c == in.ack_at) ? in.rdata : rnd64();
            #1;
            exp_stall = mem_op && (c < len);
            chk("stall", {63'd0, stall_out}, {63'd0, exp_stall});
            chk("req", {63'd0, dmemReq_out}, {63'd0, mem_op});
            chk("pcSrc", {63'd0, pcSrc_out}, {63'd0, in.isb & in.az & ~exp_stall});
            chk("brTarget", branchTarget_out, in.tgt);
            if (mem_op) begin
                chk("addr", dmemAddr_out, in.alu);
                chk("we", {63'd0, dmemWe_out}, {63'd0, in.wr & ~in.rd});
                if (in.wr && !in.rd) chk("wdata", dmemWdata_out, in.wd);
            end
            @(posedge CLOCK);
            #1;
            if (c < len) chk("bubble", {63'd0, regWrite_out}, 64'd0);
        end
        dmemAck_in = 0;
        if (mem_op && in.rd && in.wr) exp_err = 1;
        if (to) begin
            exp_rw  = 0;
            exp_err = 1;
        end else begin
            exp_rw = in.rw; exp_m2r = in.m2r; exp_alu = in.alu; exp_wreg = in.wreg;
            exp_rdata = (mem_op && in.rd) ? in.rdata : '0;
        end
        check_memwb("wb");
    endtask

    function automatic instr_t blank();
        instr_t t;
        t.isb = 0; t.rd = 0; t.wr = 0; t.rw = 0; t.m2r = 0; t.az = 0; t.stray_ack = 0;
        t.tgt = '0; t.alu = '0; t.wd = '0; t.rdata = '0; t.wreg = '0; t.ack_at = 0;
        return t;
    endfunction

    initial begin
        instr_t t;
        int     k;

        do_reset();

        t = blank(); t.rw = 1; t.wreg = 5'd5; t.alu = 64'h2A;
        run_instr(t);

        t = blank(); t.rd = 1; t.rw = 1; t.m2r = 1; t.wreg = 5'd7; t.alu = 64'h100;
        t.ack_at = 3; t.rdata = 64'hDEAD;
        run_instr(t);

        t = blank(); t.wr = 1; t.alu = 64'h40; t.wd = 64'hBEEF; t.ack_at = 1;
        run_instr(t);

        t = blank(); t.rd = 1; t.rw = 1; t.wreg = 5'd9; t.alu = 64'h200; t.ack_at = 0;
        run_instr(t);

        t = blank(); t.rw = 1; t.wreg = 5'd3; t.alu = 64'h55; t.stray_ack = 1;
        run_instr(t);

        t = blank(); t.isb = 1; t.az = 1; t.tgt = 64'h80;
        run_instr(t);
        t.az = 0;
        run_instr(t);

        // Reset while an access is outstanding, then a stale ack afterwards.
        do_reset();
        t = blank(); t.rd = 1; t.rw = 1; t.wreg = 5'd4; t.alu = 64'h300; t.isb = 1; t.az = 1;
        isBranch_in = 1; ALUzero_in = 1; memRead_in = 1; regWrite_in = 1;
        writeReg_in = 5'd4; ALUresult_in = 64'h300;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("wait_stall", {63'd0, stall_out}, 64'd1);
        RESET = 1'b1;
        #1;
        chk("rstw_req", {63'd0, dmemReq_out}, 64'd0);
        chk("rstw_stall", {63'd0, stall_out}, 64'd0);
        chk("rstw_pcSrc", {63'd0, pcSrc_out}, 64'd0);
        @(posedge CLOCK);
        #1;
        chk("rstw_req2", {63'd0, dmemReq_out}, 64'd0);
        RESET = 1'b0;
        clear_inputs();
        @(posedge CLOCK);
        #1;
        dmemAck_in = 1; dmemRdata_in = 64'h1234;
        #1;
        chk("stale_req", {63'd0, dmemReq_out}, 64'd0);
        chk("stale_stall", {63'd0, stall_out}, 64'd0);
        @(posedge CLOCK);
        #1;
        dmemAck_in = 0;
        exp_rw = 0; exp_m2r = 0; exp_rdata = '0; exp_alu = '0; exp_wreg = '0; exp_err = 0;
        check_memwb("stale");

        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            t = blank();
            k = $urandom_range(0, 19);
            t.rd  = (k >= 8 && k <= 12) || k == 19;
            t.wr  = (k >= 13 && k <= 17) || k == 19;
            t.isb = (k == 18) || ($urandom_range(0, 7) == 0);
            t.az  = $urandom_range(0, 1);
            t.rw  = $urandom_range(0, 1);
            t.m2r = $urandom_range(0, 1);
            t.stray_ack = ($urandom_range(0, 3) == 0);
            t.tgt = rnd64(); t.alu = rnd64(); t.wd = rnd64(); t.rdata = rnd64();
            t.wreg = 5'($urandom_range(0, 31));
            t.ack_at = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3)
                                                   : $urandom_range(1, TIMEOUT + 2);
            run_instr(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
